// File: rtl/dtree_pkg.sv
// Shared decision-tree definitions: record size, field offsets and node-memory state encoding.
package dtree_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2
   } mem_state_t;

   function automatic int node_size(input int features, input int coeff_w, input int bias_w);
      return 2 + features + (features - 1) * coeff_w + bias_w + 1;
   endfunction

   // LSB positions of each record field; bit 0 is the spare.
   function automatic int off_bias();
      return 1;
   endfunction

   function automatic int off_coeff(input int k, input int features, input int coeff_w,
                                    input int bias_w);
      return 1 + bias_w + (features - 2 - k) * coeff_w;
   endfunction

   function automatic int off_mask(input int features, input int coeff_w, input int bias_w);
      return 1 + bias_w + (features - 1) * coeff_w;
   endfunction

   function automatic int off_child(input int features, input int coeff_w, input int bias_w);
      return off_mask(features, coeff_w, bias_w) + features;
   endfunction

endpackage

// File: rtl/dtree_cfg_deser.sv
// Chunk-to-record assembler: shifts configuration chunks in MSB-first and emits one record
// (plus parity verdict) combinationally on the accept of its final chunk.
module dtree_cfg_deser #(
   parameter  int CFG_WIDTH = 8,
   parameter  int NODE_SIZE = 24,
   parameter  int PARITY    = 0,
   localparam int BITS      = NODE_SIZE + PARITY,
   localparam int CHUNKS    = (BITS + CFG_WIDTH - 1) / CFG_WIDTH,
   localparam int TOT       = CHUNKS * CFG_WIDTH,
   localparam int CW        = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_clr,
   input  logic                 i_accept,
   input  logic [CFG_WIDTH-1:0] i_data,
   output logic                 o_rec_valid,
   output logic [NODE_SIZE-1:0] o_rec_data,
   output logic                 o_rec_perr
);

   // Only the earlier chunks are stored; the final chunk is taken straight off the bus.
   logic [TOT-CFG_WIDTH-1:0] r_sh;
   logic [CW-1:0]            r_cnt;
   logic [TOT-1:0]           w_cat;
   logic [BITS-1:0]          w_rec;
   logic                     w_last;

   assign w_cat  = {r_sh, i_data};
   assign w_rec  = w_cat[TOT-1 -: BITS];
   assign w_last = i_accept && (r_cnt == CW'(CHUNKS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sh  <= '0;
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_accept) begin
         r_sh  <= w_cat[TOT-CFG_WIDTH-1:0];
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

   assign o_rec_valid = w_last;
   assign o_rec_data  = w_rec[BITS-1 -: NODE_SIZE];
   // Even parity: record bits plus trailing parity bit must XOR to zero.
   assign o_rec_perr  = (PARITY != 0) ? (^w_rec) : 1'b0;

endmodule

// File: rtl/dtree_node_mem.sv
// Decision-tree node memory: chunked config load, per-channel record array, combinational read.
// Optional build macro DTREE_MEM_PARITY_EN adds a per-record even-parity bit and sticky cfg_error.
module dtree_node_mem
   import dtree_pkg::*;
#(
   parameter  int FEATURES      = 3,
   parameter  int COEFF_WIDTH   = 4,
   parameter  int BIAS_WIDTH    = 10,
   parameter  int NODES         = 5,
   parameter  int CHANNEL_COUNT = 1,
   parameter  int CFG_WIDTH     = 8,
   localparam int NODE_SIZE     = node_size(FEATURES, COEFF_WIDTH, BIAS_WIDTH),
   localparam int CH_W          = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
   localparam int IX_W          = (NODES > 1) ? $clog2(NODES) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cfg_start,
   input  logic                 cfg_valid,
   input  logic [CFG_WIDTH-1:0] cfg_data,
   output logic                 cfg_ready,
   output logic                 cfg_error,
   input  logic [CH_W-1:0]      ch_index,
   input  logic [IX_W-1:0]      node_index,
   input  logic                 read_mem,
   output logic [NODE_SIZE-1:0] node_data,
   output logic                 mem_ready
);

`ifdef DTREE_MEM_PARITY_EN
   localparam int PAR_EN = 1;
`else
   localparam int PAR_EN = 0;
`endif
   localparam int DEPTH = CHANNEL_COUNT * NODES;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   mem_state_t             r_state;
   logic [AW-1:0]          r_addr;
   logic                   r_mem_ready;
   logic                   r_cfg_ready;
   logic                   r_cfg_error;
   logic [NODE_SIZE-1:0]   r_mem [DEPTH];

   logic                   w_accept;
   logic                   w_rec_valid;
   logic [NODE_SIZE-1:0]   w_rec_data;
   logic                   w_rec_perr;
   logic [AW-1:0]          w_rd_addr;
   logic                   w_in_range;
   logic                   w_sel;

   // cfg_start wins over a simultaneous chunk.
   assign w_accept = cfg_valid && r_cfg_ready && !cfg_start;

   dtree_cfg_deser #(
      .CFG_WIDTH (CFG_WIDTH),
      .NODE_SIZE (NODE_SIZE),
      .PARITY    (PAR_EN)
   ) u_deser (
      .clk         (clk),
      .reset       (reset),
      .i_clr       (cfg_start),
      .i_accept    (w_accept),
      .i_data      (cfg_data),
      .o_rec_valid (w_rec_valid),
      .o_rec_data  (w_rec_data),
      .o_rec_perr  (w_rec_perr)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_mem_ready <= 1'b0;
         r_cfg_ready <= 1'b0;
         r_cfg_error <= 1'b0;
      end else if (cfg_start) begin
         r_state     <= ST_LOAD;
         r_addr      <= '0;
         r_mem_ready <= 1'b0;
         r_cfg_ready <= 1'b1;
         r_cfg_error <= 1'b0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (w_rec_valid) begin
                  if (w_rec_perr) r_cfg_error <= 1'b1;
                  if (r_addr == AW'(DEPTH - 1)) begin
                     r_addr      <= '0;
                     r_cfg_ready <= 1'b0;
                     // A corrupted load finishes but is never exposed to the controller.
                     if (w_rec_perr || r_cfg_error) begin
                        r_state     <= ST_IDLE;
                        r_mem_ready <= 1'b0;
                     end else begin
                        r_state     <= ST_READY;
                        r_mem_ready <= 1'b1;
                     end
                  end else begin
                     r_addr <= r_addr + 1'b1;
                  end
               end
            end
            ST_READY: begin
               r_cfg_ready <= 1'b0;
               r_mem_ready <= 1'b1;
            end
            default: begin
               r_cfg_ready <= 1'b0;
               r_mem_ready <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_rec_valid) r_mem[r_addr] <= w_rec_data;
   end

   assign w_rd_addr  = AW'(32'(ch_index) * NODES + 32'(node_index));
   assign w_in_range = (32'(ch_index) < CHANNEL_COUNT) && (32'(node_index) < NODES);
   // read_mem is only a strobe: data stays level-valid through the controller's evaluate phase.
   assign w_sel      = r_mem_ready && w_in_range && (read_mem || 1'b1);
   assign node_data  = w_sel ? r_mem[w_rd_addr] : '0;

   assign mem_ready  = r_mem_ready;
   assign cfg_ready  = r_cfg_ready;
   assign cfg_error  = r_cfg_error;

endmodule

// File: tb/tb_dtree_node_mem.sv
// Scoreboard bench for dtree_node_mem with two channels of five 24-bit records.
module tb_dtree_node_mem;

   localparam int F     = 3;
   localparam int CWD   = 4;
   localparam int BW    = 10;
   localparam int N     = 5;
   localparam int CC    = 2;
   localparam int CFG   = 8;
   localparam int NS    = 2 + F + (F - 1) * CWD + BW + 1;
`ifdef DTREE_MEM_PARITY_EN
   localparam int BITS  = NS + 1;
`else
   localparam int BITS  = NS;
`endif
   localparam int CH    = (BITS + CFG - 1) / CFG;
   localparam int SH    = CH * CFG - BITS;
   localparam int DEPTH = CC * N;

   logic           clk = 1'b0;
   logic           reset;
   logic           cfg_start;
   logic           cfg_valid;
   logic [CFG-1:0] cfg_data;
   logic           cfg_ready;
   logic           cfg_error;
   logic [0:0]     ch_index;
   logic [2:0]     node_index;
   logic           read_mem;
   logic [NS-1:0]  node_data;
   logic           mem_ready;

   int checks = 0;
   int errors = 0;

   logic [NS-1:0] exp_q[$];
   logic [NS-1:0] exp_mem[DEPTH];

   dtree_node_mem #(
      .FEATURES(F), .COEFF_WIDTH(CWD), .BIAS_WIDTH(BW), .NODES(N),
      .CHANNEL_COUNT(CC), .CFG_WIDTH(CFG)
   ) u_dut (
      .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
      .cfg_data(cfg_data), .cfg_ready(cfg_ready), .cfg_error(cfg_error),
      .ch_index(ch_index), .node_index(node_index), .read_mem(read_mem),
      .node_data(node_data), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_load;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
   endtask

   task automatic send_rec(input logic [NS-1:0] rec, input bit bad_par, input int gap_pct);
      logic [BITS-1:0] rb;
      logic [31:0]     pk;
`ifdef DTREE_MEM_PARITY_EN
      rb = {rec, (^rec) ^ bad_par};
`else
      rb = rec;
      if (bad_par) rb = rec;
`endif
      pk = 32'(rb) << SH;
      pk = pk | ($urandom & ((32'd1 << SH) - 32'd1));
      for (int c = 0; c < CH; c++) begin
         while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            cfg_valid = 1'b0;
            cfg_data  = CFG'($urandom);
            tick();
         end
         cfg_valid = 1'b1;
         cfg_data  = pk[(CH-1-c)*CFG +: CFG];
         tick();
      end
      cfg_valid = 1'b0;
   endtask

   // Loads every record; good loads push their records to the scoreboard queue.
   task automatic load_all(input int gap_pct, input int bad_idx);
      logic [NS-1:0] rec;
      bool_ok: begin end
      for (int r = 0; r < DEPTH; r++) begin
         rec = NS'($urandom);
         if (bad_idx < 0) begin
            exp_q.push_back(rec);
            exp_mem[r] = rec;
         end
         send_rec(rec, (r == bad_idx), gap_pct);
         if (r == DEPTH - 2) begin
            checks++;
            if (mem_ready !== 1'b0) begin
               errors++;
               $display("FAIL early_mem_ready: got %b want 0", mem_ready);
            end
         end
`ifdef DTREE_MEM_PARITY_EN
         if (r == bad_idx) begin
            checks++;
            if (cfg_error !== 1'b1) begin
               errors++;
               $display("FAIL parity_error_set: got %b want 1", cfg_error);
            end
         end
`endif
      end
      checks++;
      if (mem_ready !== (bad_idx < 0)) begin
         errors++;
         $display("FAIL final_mem_ready: got %b want %b", mem_ready, (bad_idx < 0));
      end
      checks++;
      if (cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL final_cfg_ready: got %b want 0", cfg_ready);
      end
   endtask

   task automatic readback(input string tag);
      logic [NS-1:0] exp;
      for (int a = 0; a < DEPTH; a++) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_queue_empty: addr %0d has no expected record", tag, a);
            continue;
         end
         exp        = exp_q.pop_front();
         ch_index   = 1'(a / N);
         node_index = 3'(a % N);
         read_mem   = 1'($urandom);
         #1;
         if (node_data !== exp) begin
            errors++;
            $display("FAIL %s_read ch%0d node%0d: got %h want %h", tag, a / N, a % N,
                     node_data, exp);
         end
      end
      read_mem = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
      ch_index = '0; node_index = '0; read_mem = 1'b0;
      tick(); tick();
      checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready: got %b want 0", mem_ready); end
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_cfg_ready: got %b want 0", cfg_ready); end
      checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL reset_cfg_error: got %b want 0", cfg_error); end
      checks++; if (node_data !== '0) begin errors++; $display("FAIL reset_node_data: got %h want 0", node_data); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_full_load;
      start_load();
      checks++;
      if (cfg_ready !== 1'b1) begin errors++; $display("FAIL load_cfg_ready: got %b want 1", cfg_ready); end
      load_all(0, -1);
      readback("full");
   endtask

   task automatic test_gaps_and_ready_ignore;
      start_load();
      load_all(40, -1);
      readback("gaps");
      for (int i = 0; i < 6; i++) begin
         cfg_valid = 1'b1;
         cfg_data  = CFG'($urandom);
         tick();
      end
      cfg_valid = 1'b0;
      checks++;
      if (mem_ready !== 1'b1) begin errors++; $display("FAIL ready_ignore_mem_ready: got %b want 1", mem_ready); end
      for (int a = 0; a < DEPTH; a++) exp_q.push_back(exp_mem[a]);
      readback("ready_ignore");
   endtask

   task automatic test_restart;
      start_load();
      checks++;
      if (mem_ready !== 1'b0) begin errors++; $display("FAIL restart_drop_ready: got %b want 0", mem_ready); end
      for (int i = 0; i < 13; i++) begin
         cfg_valid = 1'b1;
         cfg_data  = CFG'($urandom);
         tick();
      end
      checks++;
      if (cfg_ready !== 1'b1 || mem_ready !== 1'b0) begin
         errors++;
         $display("FAIL partial_state: got ready %b mem %b want 1 0", cfg_ready, mem_ready);
      end
      // Chunk presented together with cfg_start must be dropped.
      cfg_start = 1'b1;
      cfg_valid = 1'b1;
      cfg_data  = CFG'($urandom);
      tick();
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      load_all(0, -1);
      readback("restart");
   endtask

   task automatic test_out_of_range;
      for (int c = 0; c < CC; c++) begin
         for (int n = N; n < 8; n++) begin
            ch_index   = 1'(c);
            node_index = 3'(n);
            #1;
            checks++;
            if (node_data !== '0) begin
               errors++;
               $display("FAIL oor ch%0d node%0d: got %h want 0", c, n, node_data);
            end
         end
      end
      ch_index = 1'b1; node_index = 3'd2; read_mem = 1'b0;
      #1;
      checks++;
      if (node_data !== exp_mem[N + 2]) begin
         errors++;
         $display("FAIL no_strobe_read: got %h want %h", node_data, exp_mem[N + 2]);
      end
   endtask

   task automatic test_reset_mid;
      ch_index = 1'b0; node_index = 3'd0;
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if (mem_ready !== 1'b0 || node_data !== '0) begin
         errors++;
         $display("FAIL async_reset: got mem %b data %h want 0 0", mem_ready, node_data);
      end
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cfg_valid = 1'b1;
         cfg_data  = CFG'($urandom);
         tick();
      end
      cfg_valid = 1'b0;
      checks++;
      if (cfg_ready !== 1'b0 || mem_ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got ready %b mem %b want 0 0", cfg_ready, mem_ready);
      end
      start_load();
      load_all(10, -1);
      readback("after_reset");
   endtask

`ifdef DTREE_MEM_PARITY_EN
   task automatic test_parity;
      start_load();
      load_all(0, 3);
      checks++;
      if (cfg_error !== 1'b1) begin errors++; $display("FAIL parity_sticky: got %b want 1", cfg_error); end
      start_load();
      checks++;
      if (cfg_error !== 1'b0) begin errors++; $display("FAIL parity_clear: got %b want 0", cfg_error); end
      load_all(0, -1);
      readback("parity_clean");
   endtask
`endif

   initial begin
      test_reset();
      test_full_load();
      test_gaps_and_ready_ignore();
      test_restart();
      test_out_of_range();
      test_reset_mid();
`ifdef DTREE_MEM_PARITY_EN
      test_parity();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
